// File: rtl/csr_ctrl_pkg.sv
// Shared constants and types for the CSR-instruction controller: FSM state
// encodings, funct3 op codes, the implemented machine-CSR map and the
// register-file side structs.
package csr_ctrl_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_READ      = 3'd1;
   localparam logic [2:0] ST_COMMIT    = 3'd2;
   localparam logic [2:0] ST_TRAP      = 3'd3;
   localparam logic [2:0] ST_TRAP_WAIT = 3'd4;
   localparam logic [2:0] ST_MRET      = 3'd5;
   localparam logic [2:0] ST_MRET_WAIT = 3'd6;

   localparam logic [2:0] OP_RW  = 3'b001;
   localparam logic [2:0] OP_RS  = 3'b010;
   localparam logic [2:0] OP_RC  = 3'b011;
   localparam logic [2:0] OP_RWI = 3'b101;
   localparam logic [2:0] OP_RSI = 3'b110;
   localparam logic [2:0] OP_RCI = 3'b111;

   typedef struct packed {
      logic        crden;
      logic [11:0] craddr;
      logic        cwren;
      logic [11:0] cwaddr;
      logic [31:0] cdata;
      logic        valid;
      logic        exception;
      logic [31:0] epc;
      logic [31:0] etval;
      logic [3:0]  ecause;
      logic        mret;
   } csr_in_type;

   typedef struct packed {
      logic [31:0] cdata;
      logic        exception;
      logic        mret;
      logic [31:0] mepc;
      logic [31:0] mtvec;
   } csr_out_type;

   // The sixteen machine CSRs backed by the register file.
   function automatic logic csr_implemented(input logic [11:0] addr);
      case (addr)
         12'h300, 12'h301, 12'h304, 12'h305,
         12'h306, 12'h340, 12'h341, 12'h342,
         12'h343, 12'h344, 12'hB00, 12'hB02,
         12'hF11, 12'hF12, 12'hF13, 12'hF14: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   function automatic logic op_legal(input logic [2:0] op);
      case (op)
         OP_RW, OP_RS, OP_RC, OP_RWI, OP_RSI, OP_RCI: return 1'b1;
         default:                                     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/csr_ctrl_if.sv
// Pipeline-facing signals of the CSR controller: CSR instruction request and
// response, trap and mret requests, retire strobe and the fetch redirect.
interface csr_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [11:0] req_addr;
   logic [31:0] req_rs1;
   logic [4:0]  req_uimm;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_illegal;
   logic        trap_req;
   logic        trap_ready;
   logic [3:0]  trap_cause;
   logic [31:0] trap_epc;
   logic [31:0] trap_tval;
   logic        mret_req;
   logic        retire;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport master (
      output req_valid, req_op, req_addr, req_rs1, req_uimm,
      output trap_req, trap_cause, trap_epc, trap_tval, mret_req, retire,
      input  req_ready, rsp_valid, rsp_data, rsp_illegal,
      input  trap_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_rs1, req_uimm,
      input  trap_req, trap_cause, trap_epc, trap_tval, mret_req, retire,
      output req_ready, rsp_valid, rsp_data, rsp_illegal,
      output trap_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/csr_ctrl_alu.sv
// Read-modify-write datapath for CSR instructions: new value and write enable
// from the op, the old CSR value and the rs1/zimm source.
module csr_ctrl_alu
   import csr_ctrl_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] old_val,
   input  logic [31:0] rs1,
   input  logic [4:0]  uimm,
   output logic [31:0] new_val,
   output logic        wen
);

   logic [31:0] src;

   // Set/clear forms with a zero rs1 index or zimm are pure reads.
   always_comb begin
      src     = op[2] ? {27'b0, uimm} : rs1;
      new_val = 32'h0;
      wen     = 1'b0;
      case (op)
         OP_RW, OP_RWI: begin
            new_val = src;
            wen     = 1'b1;
         end
         OP_RS, OP_RSI: begin
            new_val = old_val | src;
            wen     = (uimm != 5'd0);
         end
         OP_RC, OP_RCI: begin
            new_val = old_val & ~src;
            wen     = (uimm != 5'd0);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/csr_ctrl.sv
// CSR controller: sequences CSR read-modify-write instructions, trap entry and
// mret against an external CSR register file, and issues fetch redirects.
//
// state      | meaning
// IDLE       | accept trap > mret > CSR request
// READ       | read CSR, capture old value
// COMMIT     | write new value, respond with old value
// TRAP       | one-cycle exception pulse to the register file
// TRAP_WAIT  | wait for register file ack, redirect to mtvec
// MRET       | one-cycle mret pulse to the register file
// MRET_WAIT  | wait for register file ack, redirect to mepc
module csr_ctrl
   import csr_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   csr_ctrl_if.slave   bus,
   output csr_in_type  csr_in,
   input  csr_out_type csr_out
);

   logic [2:0]  state_q, state_d;
   logic [2:0]  op_q;
   logic [11:0] addr_q;
   logic [31:0] rs1_q;
   logic [4:0]  uimm_q;
   logic [31:0] old_q;
   logic [3:0]  cause_q;
   logic [31:0] epc_q;
   logic [31:0] tval_q;
   logic [31:0] new_val;
   logic        wen;
   logic        illegal;
   logic        req_go;
   logic        trap_go;

   csr_ctrl_alu u_alu (
      .op      (op_q),
      .old_val (old_q),
      .rs1     (rs1_q),
      .uimm    (uimm_q),
      .new_val (new_val),
      .wen     (wen)
   );

   // Writes to the read-only quadrant are illegal even if the CSR exists.
   always_comb begin
      illegal = !csr_implemented(addr_q) || !op_legal(op_q)
                || (wen && (addr_q[11:10] == 2'b11));
   end

   // Handshake transfers and next-state selection.
   always_comb begin
      trap_go = (state_q == ST_IDLE) && bus.trap_req;
      req_go  = (state_q == ST_IDLE) && !bus.trap_req && !bus.mret_req && bus.req_valid;
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.trap_req)       state_d = ST_TRAP;
            else if (bus.mret_req)  state_d = ST_MRET;
            else if (bus.req_valid) state_d = ST_READ;
         end
         ST_READ:      state_d = ST_COMMIT;
         ST_COMMIT:    state_d = ST_IDLE;
         ST_TRAP:      state_d = ST_TRAP_WAIT;
         ST_TRAP_WAIT: if (csr_out.exception) state_d = ST_IDLE;
         ST_MRET:      state_d = ST_MRET_WAIT;
         ST_MRET_WAIT: if (csr_out.mret) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // State register and request/trap payload latches.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         op_q    <= 3'd0;
         addr_q  <= 12'd0;
         rs1_q   <= 32'd0;
         uimm_q  <= 5'd0;
         old_q   <= 32'd0;
         cause_q <= 4'd0;
         epc_q   <= 32'd0;
         tval_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         if (req_go) begin
            op_q   <= bus.req_op;
            addr_q <= bus.req_addr;
            rs1_q  <= bus.req_rs1;
            uimm_q <= bus.req_uimm;
         end
         if (trap_go) begin
            cause_q <= bus.trap_cause;
            epc_q   <= bus.trap_epc;
            tval_q  <= bus.trap_tval;
         end
         if (state_q == ST_READ) old_q <= illegal ? 32'h0 : csr_out.cdata;
      end
   end

   // Output decode; everything but the retire strobe is held low in reset.
   always_comb begin
      csr_in             = '0;
      csr_in.valid       = bus.retire;
      bus.req_ready      = 1'b0;
      bus.trap_ready     = 1'b0;
      bus.rsp_valid      = 1'b0;
      bus.rsp_data       = 32'h0;
      bus.rsp_illegal    = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      if (rst) begin
         case (state_q)
            ST_IDLE: begin
               bus.trap_ready = 1'b1;
               bus.req_ready  = !bus.trap_req && !bus.mret_req;
            end
            ST_READ: begin
               if (!illegal) begin
                  csr_in.crden  = 1'b1;
                  csr_in.craddr = addr_q;
               end
            end
            ST_COMMIT: begin
               bus.rsp_valid   = 1'b1;
               bus.rsp_illegal = illegal;
               bus.rsp_data    = old_q;
               if (wen && !illegal) begin
                  csr_in.cwren  = 1'b1;
                  csr_in.cwaddr = addr_q;
                  csr_in.cdata  = new_val;
               end
            end
            ST_TRAP: begin
               csr_in.exception = 1'b1;
               csr_in.epc       = epc_q;
               csr_in.etval     = tval_q;
               csr_in.ecause    = cause_q;
            end
            ST_TRAP_WAIT: begin
               if (csr_out.exception) begin
                  bus.redirect_valid = 1'b1;
                  bus.redirect_pc    = csr_out.mtvec;
               end
            end
            ST_MRET: csr_in.mret = 1'b1;
            ST_MRET_WAIT: begin
               if (csr_out.mret) begin
                  bus.redirect_valid = 1'b1;
                  bus.redirect_pc    = csr_out.mepc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
